ps2_key_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_evt_fifo.sv | 51 +++++
 rtl/ps2_key_rx.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_key_rx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
    localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead FIFO of key events; head reads as zero when empty.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  key_evt_t push_data,
    input  logic     pop_req,
    output key_evt_t head,
    output logic     valid,
    output logic     drop
);

    localparam int AW = $clog2(DEPTH);

    key_evt_t       mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           empty;
    logic           full;
    logic           pop;
    logic           wr_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg == {~rd_ptr_reg[AW], rd_ptr_reg[AW-1:0]});
    assign pop   = pop_req && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign head  = empty ? key_evt_t'('0) : mem[rd_ptr_reg[AW-1:0]];
    assign valid = !empty;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: sync, deframe, E0/F0 folding, event FIFO.
// Optional PS2_GLITCH_FILTER_EN adds a stability filter on ps2_clk.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam longint TO_CYCLES = longint'(TIMEOUT_US) * longint'(CLK_FREQ_HZ) / 64'sd1_000_000;
    localparam int TO_W = $clog2(TO_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_f;
    logic                   data_f;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
    assign data_s = data_sync_reg[SYNC_STAGES-1];

`ifdef PS2_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN) + 1;

    logic [FW-1:0]         filt_cnt_reg;
    logic                  filt_lvl_reg;
    logic [FILTER_LEN-1:0] data_dly_reg;

    // Data is delayed by the filter latency so it stays aligned with the clock fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt_reg <= '0;
            filt_lvl_reg <= 1'b1;
            data_dly_reg <= '1;
        end else begin
            data_dly_reg <= {data_dly_reg[FILTER_LEN-2:0], data_s};
            if (clk_s == filt_lvl_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
                filt_lvl_reg <= clk_s;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

    assign clk_f  = filt_lvl_reg;
    assign data_f = data_dly_reg[FILTER_LEN-1];
`else
    assign clk_f  = clk_s;
    assign data_f = data_s;
`endif

    logic            prev_clk_reg;
    logic            fall;
    rx_state_t       state_reg, state_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            parity_reg, parity_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            byte_done_reg, byte_done_next;
    logic            frame_err_reg, frame_err_next;
    logic            timeout;

    assign fall    = prev_clk_reg && !clk_f;
    assign timeout = (state_reg != IDLE) && (to_cnt_reg == TO_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_clk_reg  <= 1'b1;
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            to_cnt_reg    <= '0;
            byte_done_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            prev_clk_reg  <= clk_f;
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            parity_reg    <= parity_next;
            to_cnt_reg    <= to_cnt_next;
            byte_done_reg <= byte_done_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        parity_next    = parity_reg;
        byte_done_next = 1'b0;
        frame_err_next = 1'b0;
        if (state_reg == IDLE || fall) to_cnt_next = '0;
        else                           to_cnt_next = to_cnt_reg + 1'b1;

        if (timeout) begin
            state_next     = IDLE;
            frame_err_next = 1'b1;
            to_cnt_next    = '0;
        end else if (fall) begin
            case (state_reg)
                IDLE: begin
                    if (!data_f) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {data_f, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7) state_next = PARITY;
                end
                PARITY: begin
                    parity_next = data_f;
                    state_next  = STOP;
                end
                STOP: begin
                    if (data_f && ((^shift_reg) ^ parity_reg)) byte_done_next = 1'b1;
                    else                                         frame_err_next = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    logic     ext_pend_reg;
    logic     brk_pend_reg;
    logic     push;
    key_evt_t push_evt;
    key_evt_t head;
    logic     drop;
    logic     overflow_reg;

    // shift_reg is still holding the finished byte while byte_done_reg is high.
    assign push = byte_done_reg && (shift_reg != PS2_EXT_CODE) && (shift_reg != PS2_BRK_CODE);
    assign push_evt = '{ext: ext_pend_reg, brk: brk_pend_reg, code: shift_reg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_pend_reg <= 1'b0;
            brk_pend_reg <= 1'b0;
        end else if (frame_err_reg) begin
            ext_pend_reg <= 1'b0;
            brk_pend_reg <= 1'b0;
        end else if (byte_done_reg) begin
            if (shift_reg == PS2_EXT_CODE) begin
                ext_pend_reg <= 1'b1;
            end else if (shift_reg == PS2_BRK_CODE) begin
                brk_pend_reg <= 1'b1;
            end else begin
                ext_pend_reg <= 1'b0;
                brk_pend_reg <= 1'b0;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_evt),
        .pop_req   (key_ready),
        .head      (head),
        .valid     (key_valid),
        .drop      (drop)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          overflow_reg <= 1'b0;
        else if (drop)         overflow_reg <= 1'b1;
        else if (clr_overflow) overflow_reg <= 1'b0;
    end

    assign key_code  = head.code;
    assign key_ext   = head.ext;
    assign key_break = head.brk;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: 1 MHz clock so 1 clk = 1 us, FIFO depth 4.
`timescale 1ns/1ps
module tb_ps2_key_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       frame_err;
    logic       overflow;
    logic       clr_overflow = 1'b0;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int fe_exp = 0;
    logic [9:0] sb [$];

    always #500 clk = ~clk;

    ps2_key_rx #(
        .CLK_FREQ_HZ (1_000_000),
        .TIMEOUT_US  (2000),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2),
        .FILTER_LEN  (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_break    (key_break),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit period 80 us: data set mid-high, clock low for 40 us.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(40);
            ps2_clk = 1'b0;
            tick(40);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(f, 11);
        tick(200);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic end_of_test(input string name);
        tick(50);
        check({name, " pending events"}, sb.size(), 0);
        check({name, " frame_err count"}, fe_cnt, fe_exp);
    endtask

    initial begin
        logic [9:0] exp_evt;
        logic [9:0] act_evt;
        fork
            forever begin
                @(negedge clk);
                if (frame_err) fe_cnt++;
                if (key_valid && key_ready) begin
                    act_evt = {key_ext, key_break, key_code};
                    if (sb.size() == 0) begin
                        check("unexpected event", int'(act_evt), 0);
                    end else begin
                        exp_evt = sb.pop_front();
                        $display("event code=%02h ext=%0b brk=%0b", key_code, key_ext, key_break);
                        check("event", int'(act_evt), int'(exp_evt));
                    end
                end
            end
            begin
                tick(5);
                check("reset key_valid", key_valid, 0);
                check("reset key_code", key_code, 0);
                check("reset frame_err", frame_err, 0);
                check("reset overflow", overflow, 0);
                reset_n = 1'b1;
                tick(20);

                sb.push_back({2'b00, 8'h1C});
                send_byte(8'h1C, 1'b0);
                end_of_test("plain 1C");

                sb.push_back({2'b11, 8'h75});
                send_byte(8'hE0, 1'b0);
                send_byte(8'hF0, 1'b0);
                send_byte(8'h75, 1'b0);
                end_of_test("E0 F0 75");

                fe_exp++;
                send_byte(8'h1C, 1'b1);
                sb.push_back({2'b00, 8'h29});
                send_byte(8'h29, 1'b0);
                end_of_test("parity error");

                send_bits(11'b000_0011_0100, 6);
                tick(2500);
                fe_exp++;
                sb.push_back({2'b00, 8'h29});
                send_byte(8'h29, 1'b0);
                end_of_test("timeout");

                key_ready = 1'b0;
                sb.push_back({2'b00, 8'h16});
                sb.push_back({2'b00, 8'h1E});
                sb.push_back({2'b00, 8'h26});
                sb.push_back({2'b00, 8'h25});
                send_byte(8'h16, 1'b0);
                send_byte(8'h1E, 1'b0);
                send_byte(8'h26, 1'b0);
                send_byte(8'h25, 1'b0);
                send_byte(8'h2E, 1'b0);
                check("overflow set", overflow, 1);
                check("show-ahead head", key_code, 8'h16);
                key_ready = 1'b1;
                end_of_test("overflow");
                clr_overflow = 1'b1;
                tick(1);
                clr_overflow = 1'b0;
                tick(1);
                check("overflow cleared", overflow, 0);

                send_bits(11'b000_0011_1000, 5);
                tick(10);
                reset_n = 1'b0;
                tick(5);
                reset_n = 1'b1;
                tick(20);
                sb.push_back({2'b00, 8'h1C});
                send_byte(8'h1C, 1'b0);
                end_of_test("reset mid-frame");
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
